alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 110 +++++++++++
 rtl/alu_issue_if.sv | 37 +++
 rtl/regfile32.sv | 38 +++
 rtl/alu_issue.sv | 129 ++++++++++++
 tb/tb_alu_issue.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice: instruction field positions,
// opcode/sub-op encodings, issue FSM states and the instruction decoder.
package alu_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    // Instruction word field positions
    localparam int ILLEGAL_BIT = 31;
    localparam int OPC_MSB     = 30;
    localparam int OPC_LSB     = 25;
    localparam int RT_MSB      = 24;
    localparam int RT_LSB      = 20;
    localparam int RA_MSB      = 19;
    localparam int RA_LSB      = 15;
    localparam int RB_MSB      = 14;
    localparam int RB_LSB      = 10;
    localparam int IMM15_MSB   = 14;
    localparam int IMM15_LSB   = 0;
    localparam int SUB_MSB     = 4;
    localparam int SUB_LSB     = 0;

    typedef enum logic [5:0] {
        OPC_ARITH = 6'b100000,
        OPC_ADDI  = 6'b101000,
        OPC_ORI   = 6'b101100,
        OPC_XORI  = 6'b101011
    } opcode_e;

    typedef enum logic [4:0] {
        SUB_ADD   = 5'b00000,
        SUB_SUB   = 5'b00001,
        SUB_AND   = 5'b00010,
        SUB_XOR   = 5'b00011,
        SUB_OR    = 5'b00100,
        SUB_SLLI  = 5'b01000,
        SUB_SRLI  = 5'b01001,
        SUB_ROTRI = 5'b01011
    } sub_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    // Source of the second ALU operand
    typedef enum logic [1:0] {
        SCR2_REG    = 2'd0,
        SCR2_IMM5   = 2'd1,
        SCR2_SIMM15 = 2'd2,
        SCR2_ZIMM15 = 2'd3
    } scr2_sel_e;

    typedef struct packed {
        logic              legal;
        logic [5:0]        opcode;
        logic [4:0]        sub_op;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;    // doubles as imm5 for shift/rotate
        logic [14:0]       imm15;
        scr2_sel_e         scr2_sel;
    } decode_t;

    // Splits an instruction word into fields and classifies it.
    function automatic decode_t decode(input logic [31:0] w);
        decode_t d;
        d          = '0;
        d.opcode   = w[OPC_MSB:OPC_LSB];
        d.rt       = w[RT_MSB:RT_LSB];
        d.ra       = w[RA_MSB:RA_LSB];
        d.rb       = w[RB_MSB:RB_LSB];
        d.imm15    = w[IMM15_MSB:IMM15_LSB];
        d.scr2_sel = SCR2_REG;
        case (w[OPC_MSB:OPC_LSB])
            OPC_ARITH: begin
                d.sub_op = w[SUB_MSB:SUB_LSB];
                case (w[SUB_MSB:SUB_LSB])
                    SUB_ADD, SUB_SUB, SUB_AND, SUB_XOR, SUB_OR: d.legal = 1'b1;
                    SUB_SLLI, SUB_SRLI, SUB_ROTRI: begin
                        d.legal    = 1'b1;
                        d.scr2_sel = SCR2_IMM5;
                    end
                    default: d.legal = 1'b0;
                endcase
            end
            OPC_ADDI: begin
                d.legal    = 1'b1;
                d.scr2_sel = SCR2_SIMM15;
            end
            OPC_ORI, OPC_XORI: begin
                d.legal    = 1'b1;
                d.scr2_sel = SCR2_ZIMM15;
            end
            default: d.legal = 1'b0;
        endcase
        if (w[ILLEGAL_BIT]) d.legal = 1'b0;
        return d;
    endfunction

    function automatic logic is_legal(input logic [31:0] w);
        decode_t d;
        d = decode(w);
        return d.legal;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction, ALU operand/result and writeback signals of the issue block.
// The slave modport is the issue block; master is the environment that
// offers instructions, hosts the ALU and consumes writebacks.
interface alu_issue_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic [5:0]        alu_opcode;
    logic [4:0]        alu_sub_opcode;
    logic [DATA_W-1:0] alu_scr1;
    logic [DATA_W-1:0] alu_scr2;
    logic              alu_enable_execute;
    logic              alu_reset;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_overflow;
    logic              illegal;

    modport slave (
        input  instr_valid, instr, alu_result, alu_overflow,
        output instr_ready, alu_opcode, alu_sub_opcode, alu_scr1, alu_scr2,
               alu_enable_execute, alu_reset,
               wb_valid, wb_rd, wb_data, wb_overflow, illegal
    );

    modport master (
        output instr_valid, instr, alu_result, alu_overflow,
        input  instr_ready, alu_opcode, alu_sub_opcode, alu_scr1, alu_scr2,
               alu_enable_execute, alu_reset,
               wb_valid, wb_rd, wb_data, wb_overflow, illegal
    );
endinterface

// File: rtl/regfile32.sv
// 32 x DATA_W register file: one synchronous write port, two combinational
// operand read ports, one combinational debug read port, synchronous clear.
module regfile32
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Clear every entry on reset, otherwise perform the single write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the whole array is cleared because software relies on
            // all registers reading zero after reset; this keeps it in flops.
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a   = mem[raddr_a];
    assign rdata_b   = mem[raddr_b];
    assign rdata_dbg = mem[raddr_dbg];

endmodule

// File: rtl/alu_issue.sv
// Issues one instruction at a time to an external ALU:
// IDLE (accept) -> SETUP (operands, ALU held in reset) -> EXEC (execute,
// sample result) -> WB (report and write back). Illegal words pulse
// `illegal` in SETUP and return to IDLE without executing.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_if.slave        bus,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_waddr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    state_e            state;
    logic [31:0]       instr_q;
    logic              illegal_q;
    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_ov_q;

    decode_t           dec;
    logic              in_legal;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              operands_on;

    assign dec      = decode(instr_q);
    assign in_legal = is_legal(bus.instr);

    // Register writes: external preload only while idle, result only in WB.
    assign rf_we    = reset && ((state == ST_IDLE && ext_we) || state == ST_WB);
    assign rf_waddr = (state == ST_WB) ? wb_rd_q   : ext_waddr;
    assign rf_wdata = (state == ST_WB) ? wb_data_q : ext_wdata;

    regfile32 #(.DATA_W(DATA_W)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (dec.ra),
        .rdata_a   (rdata_a),
        .raddr_b   (dec.rb),
        .rdata_b   (rdata_b),
        .raddr_dbg (dbg_raddr),
        .rdata_dbg (dbg_rdata)
    );

    // Status outputs are forced inactive while reset is held low.
    assign bus.instr_ready        = reset && (state == ST_IDLE);
    assign bus.wb_valid           = reset && wb_valid_q;
    assign bus.wb_rd              = wb_rd_q;
    assign bus.wb_data            = wb_data_q;
    assign bus.wb_overflow        = wb_ov_q;
    assign bus.illegal            = reset && illegal_q;
    assign bus.alu_enable_execute = reset && (state == ST_EXEC);
    assign bus.alu_reset          = !(reset && state == ST_EXEC);

    assign operands_on = reset && dec.legal && (state == ST_SETUP || state == ST_EXEC);

    // Operand bus: register reads and immediates, zero outside SETUP/EXEC.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bus.alu_opcode     = '0;
        bus.alu_sub_opcode = '0;
        bus.alu_scr1       = '0;
        bus.alu_scr2       = '0;
        if (operands_on) begin
            bus.alu_opcode     = dec.opcode;
            bus.alu_sub_opcode = dec.sub_op;
            bus.alu_scr1       = rdata_a;
            case (dec.scr2_sel)
                SCR2_REG:    bus.alu_scr2 = rdata_b;
                SCR2_IMM5:   bus.alu_scr2 = {{(DATA_W-5){1'b0}}, dec.rb};
                SCR2_SIMM15: bus.alu_scr2 = {{(DATA_W-15){dec.imm15[14]}}, dec.imm15};
                SCR2_ZIMM15: bus.alu_scr2 = {{(DATA_W-15){1'b0}}, dec.imm15};
                default:     bus.alu_scr2 = '0;
            endcase
        end
    end

    // Issue FSM with its registered illegal and writeback outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            instr_q    <= '0;
            illegal_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_ov_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees the
            // pre-edge state, exactly like the flops they describe.
            illegal_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q   <= bus.instr;
                        illegal_q <= !in_legal;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: state <= dec.legal ? ST_EXEC : ST_IDLE;
                ST_EXEC: begin
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= dec.rt;
                    wb_data_q  <= bus.alu_result;
                    wb_ov_q    <= bus.alu_overflow;
                    state      <= ST_WB;
                end
                ST_WB:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU attached to the
// operand bus. Expected results are hand-computed constants.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ext_we = 1'b0;
    logic [4:0]  ext_waddr = '0;
    logic [31:0] ext_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    alu_issue_if #(.DATA_W(32)) ifc ();

    alu_issue #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifc.slave),
        .ext_we    (ext_we),
        .ext_waddr (ext_waddr),
        .ext_wdata (ext_wdata),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_ov;
    assign alu_a = ifc.alu_scr1;
    assign alu_b = ifc.alu_scr2;
    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (ifc.alu_opcode)
            6'b100000: begin
                case (ifc.alu_sub_opcode)
                    5'b00000: begin
                        alu_res = alu_a + alu_b;
                        alu_ov  = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
                    end
                    5'b00001: begin
                        alu_res = alu_a - alu_b;
                        alu_ov  = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
                    end
                    5'b00010: alu_res = alu_a & alu_b;
                    5'b00011: alu_res = alu_a ^ alu_b;
                    5'b00100: alu_res = alu_a | alu_b;
                    5'b01000: alu_res = alu_a << alu_b[4:0];
                    5'b01001: alu_res = alu_a >> alu_b[4:0];
                    5'b01011: alu_res = (alu_a >> alu_b[4:0]) | (alu_a << (32 - int'(alu_b[4:0])));
                    default:  alu_res = '0;
                endcase
            end
            6'b101000: begin
                alu_res = alu_a + alu_b;
                alu_ov  = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            6'b101100: alu_res = alu_a | alu_b;
            6'b101011: alu_res = alu_a ^ alu_b;
            default:   alu_res = '0;
        endcase
    end
    assign ifc.alu_result   = alu_res;
    assign ifc.alu_overflow = alu_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [4:0] rb,
                                          input logic [4:0] sub);
        return {1'b0, op, rt, ra, rb, 5'b00000, sub};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [14:0] imm);
        return {1'b0, op, rt, ra, imm};
    endfunction

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
        dbg_raddr = a;
        #1;
        d = dbg_rdata;
    endtask

    // Called at a negedge while idle
    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        ext_we    = 1'b1;
        ext_waddr = a;
        ext_wdata = d;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    // Offers one instruction at a negedge while idle and watches five cycles.
    // Cycle k=1 is the cycle after the accepting edge.
    task automatic issue(input logic [31:0] w, output int wb_cyc, output int wb_cnt,
                         output logic [4:0] wrd, output logic [31:0] wdata,
                         output logic wov, output int ill_cyc, output int ill_cnt,
                         output int exe_cnt);
        ifc.instr_valid = 1'b1;
        ifc.instr       = w;
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        ext_we          = 1'b0;
        wb_cyc = 0; wb_cnt = 0; ill_cyc = 0; ill_cnt = 0; exe_cnt = 0;
        wrd = '0; wdata = '0; wov = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (ifc.wb_valid) begin
                wb_cnt++;
                if (wb_cyc == 0) begin
                    wb_cyc = k;
                    wrd    = ifc.wb_rd;
                    wdata  = ifc.wb_data;
                    wov    = ifc.wb_overflow;
                end
            end
            if (ifc.illegal) begin
                ill_cnt++;
                if (ill_cyc == 0) ill_cyc = k;
            end
            if (ifc.alu_enable_execute) exe_cnt++;
            if (k < 5) @(negedge clk);
        end
    endtask

    task automatic run_legal(input string tag, input logic [31:0] w, input logic [4:0] exp_rd,
                             input logic [31:0] exp_data, input logic exp_ov);
        int wb_cyc, wb_cnt, ill_cyc, ill_cnt, exe_cnt;
        logic [4:0]  wrd;
        logic [31:0] wdata, rv;
        logic        wov;
        issue(w, wb_cyc, wb_cnt, wrd, wdata, wov, ill_cyc, ill_cnt, exe_cnt);
        check({tag, "/wb_cycle"}, wb_cyc, 3);
        check({tag, "/wb_count"}, wb_cnt, 1);
        check({tag, "/wb_rd"}, {27'b0, wrd}, {27'b0, exp_rd});
        check({tag, "/wb_data"}, wdata, exp_data);
        check({tag, "/wb_ovf"}, {31'b0, wov}, {31'b0, exp_ov});
        check({tag, "/exec_count"}, exe_cnt, 1);
        check({tag, "/illegal_count"}, ill_cnt, 0);
        rd_reg(exp_rd, rv);
        check({tag, "/reg_written"}, rv, exp_data);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] w);
        int wb_cyc, wb_cnt, ill_cyc, ill_cnt, exe_cnt;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        wov;
        issue(w, wb_cyc, wb_cnt, wrd, wdata, wov, ill_cyc, ill_cnt, exe_cnt);
        check({tag, "/illegal_cycle"}, ill_cyc, 1);
        check({tag, "/illegal_count"}, ill_cnt, 1);
        check({tag, "/wb_count"}, wb_cnt, 0);
        check({tag, "/exec_count"}, exe_cnt, 0);
    endtask

    initial begin
        logic [31:0] rv;
        int          nz;
        int          wb_seen;
        bit          ready_low;

        ifc.instr_valid = 1'b0;
        ifc.instr       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst/instr_ready", {31'b0, ifc.instr_ready}, 32'd0);
        check("rst/wb_valid", {31'b0, ifc.wb_valid}, 32'd0);
        check("rst/illegal", {31'b0, ifc.illegal}, 32'd0);
        check("rst/alu_enable", {31'b0, ifc.alu_enable_execute}, 32'd0);
        check("rst/alu_reset", {31'b0, ifc.alu_reset}, 32'd1);
        check("rst/scr1", ifc.alu_scr1, 32'd0);
        check("rst/opcode", {26'b0, ifc.alu_opcode}, 32'd0);
        reset = 1'b1;
        #1;
        check("idle/instr_ready", {31'b0, ifc.instr_ready}, 32'd1);
        check("idle/alu_reset", {31'b0, ifc.alu_reset}, 32'd1);
        @(negedge clk);

        // Preload, including r0
        preload(5'd1, 32'h0000_162E);
        preload(5'd2, 32'h0000_04D2);
        preload(5'd0, 32'h0000_0055);
        rd_reg(5'd1, rv); check("preload/r1", rv, 32'h0000_162E);
        rd_reg(5'd0, rv); check("preload/r0", rv, 32'h0000_0055);

        // Register-register and shift/rotate operations
        run_legal("add",   enc_r(6'b100000, 5'd3, 5'd1, 5'd2, 5'b00000), 5'd3, 32'h0000_1B00, 1'b0);
        run_legal("sub",   enc_r(6'b100000, 5'd3, 5'd1, 5'd2, 5'b00001), 5'd3, 32'h0000_115C, 1'b0);
        run_legal("srli",  enc_r(6'b100000, 5'd4, 5'd1, 5'd3, 5'b01001), 5'd4, 32'h0000_02C5, 1'b0);
        run_legal("slli",  enc_r(6'b100000, 5'd4, 5'd1, 5'd3, 5'b01000), 5'd4, 32'h0000_B170, 1'b0);
        run_legal("rotri", enc_r(6'b100000, 5'd4, 5'd1, 5'd3, 5'b01011), 5'd4, 32'hC000_02C5, 1'b0);

        // Immediate forms
        run_legal("addi", enc_i(6'b101000, 5'd5, 5'd1, 15'h7FFF), 5'd5, 32'h0000_162D, 1'b0);
        run_legal("xori", enc_i(6'b101011, 5'd5, 5'd1, 15'h70F0), 5'd5, 32'h0000_66DE, 1'b0);
        run_legal("ori",  enc_i(6'b101100, 5'd5, 5'd1, 15'h0001), 5'd5, 32'h0000_162F, 1'b0);

        // Overflowing result is still written back
        preload(5'd6, 32'h7FFF_FFFF);
        preload(5'd7, 32'h0000_0001);
        run_legal("add_ovf", enc_r(6'b100000, 5'd8, 5'd6, 5'd7, 5'b00000), 5'd8, 32'h8000_0000, 1'b1);

        // Illegal words leave registers untouched
        run_illegal("ill_bit31", 32'h8000_0000 | enc_r(6'b100000, 5'd3, 5'd1, 5'd2, 5'b00000));
        rd_reg(5'd3, rv); check("ill_bit31/r3_kept", rv, 32'h0000_115C);
        run_illegal("ill_subop", enc_r(6'b100000, 5'd4, 5'd1, 5'd2, 5'b11111));
        rd_reg(5'd4, rv); check("ill_subop/r4_kept", rv, 32'hC000_02C5);

        // ext_we coinciding with acceptance: SETUP reads the new value
        ext_we    = 1'b1;
        ext_waddr = 5'd11;
        ext_wdata = 32'h0000_0100;
        run_legal("coincide", enc_r(6'b100000, 5'd12, 5'd1, 5'd11, 5'b00000), 5'd12, 32'h0000_172E, 1'b0);

        // ext_we ignored in SETUP/EXEC/WB
        ifc.instr_valid = 1'b1;
        ifc.instr       = enc_r(6'b100000, 5'd13, 5'd1, 5'd2, 5'b00000);
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        ext_we    = 1'b1;
        ext_waddr = 5'd9;
        ext_wdata = 32'h0000_DEAD;
        repeat (3) @(negedge clk);
        ext_we = 1'b0;
        @(negedge clk);
        rd_reg(5'd9, rv);  check("ext_busy/r9_kept", rv, 32'h0000_0000);
        rd_reg(5'd13, rv); check("ext_busy/r13", rv, 32'h0000_1B00);

        // Back-to-back with instr_valid held; second reads the first's result
        ready_low = 1'b1;
        ifc.instr_valid = 1'b1;
        ifc.instr       = enc_r(6'b100000, 5'd3, 5'd1, 5'd2, 5'b00000);
        @(negedge clk);
        ifc.instr = enc_r(6'b100000, 5'd4, 5'd3, 5'd3, 5'b00000);
        for (int k = 1; k <= 3; k++) begin
            if (ifc.instr_ready) ready_low = 1'b0;
            if (k == 3) begin
                check("b2b/first_wb_valid", {31'b0, ifc.wb_valid}, 32'd1);
                check("b2b/first_wb_data", ifc.wb_data, 32'h0000_1B00);
            end
            @(negedge clk);
        end
        check("b2b/ready_low_busy", {31'b0, ready_low}, 32'd1);
        check("b2b/ready_high_idle", {31'b0, ifc.instr_ready}, 32'd1);
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b/second_wb_valid", {31'b0, ifc.wb_valid}, 32'd1);
        check("b2b/second_wb_rd", {27'b0, ifc.wb_rd}, 32'd4);
        check("b2b/second_wb_data", ifc.wb_data, 32'h0000_3600);
        @(negedge clk);

        // Reset during EXEC drops the instruction and clears registers
        wb_seen = 0;
        ifc.instr_valid = 1'b1;
        ifc.instr       = enc_r(6'b100000, 5'd14, 5'd1, 5'd2, 5'b00000);
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        check("rst_exec/in_exec", {31'b0, ifc.alu_enable_execute}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_exec/enable_low", {31'b0, ifc.alu_enable_execute}, 32'd0);
        check("rst_exec/alu_reset", {31'b0, ifc.alu_reset}, 32'd1);
        check("rst_exec/scr1", ifc.alu_scr1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ifc.wb_valid) wb_seen++;
            if (ifc.instr_ready) wb_seen += 100;
        end
        check("rst_exec/no_wb_no_ready", wb_seen, 0);
        reset = 1'b1;
        #1;
        check("rst_exec/ready_after", {31'b0, ifc.instr_ready}, 32'd1);
        nz = 0;
        for (int r = 0; r < 32; r++) begin
            rd_reg(r[4:0], rv);
            if (rv !== 32'd0) nz++;
        end
        check("rst_exec/regs_cleared", nz, 0);
        @(negedge clk);
        check("rst_exec/wb_after", {31'b0, ifc.wb_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
